// File: rtl/line_mem_responder_if.sv
// Line transfer bus between a cache controller (master) and the backing memory (slave).
// Whole-line read/write requests with a single-cycle completion grant.
interface line_mem_responder_if #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9
);
  localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

  logic [ADDR_LEN-1:0]        addr;
  logic                       rd_req;
  logic                       wr_req;
  logic [LINE_SIZE-1:0][31:0] wr_line;
  logic [LINE_SIZE-1:0][31:0] rd_line;
  logic                       gnt;

  modport master (
    output addr, rd_req, wr_req, wr_line,
    input  gnt, rd_line
  );

  modport slave (
    input  addr, rd_req, wr_req, wr_line,
    output gnt, rd_line
  );
endinterface

// File: rtl/line_mem_responder.sv
// Line-granular main-memory responder: accepts one line read or write at a time,
// waits a fixed latency, performs the access and pulses gnt for one cycle.
module line_mem_responder #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int ADDR_LEN      = 9,
  parameter int LATENCY       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  line_mem_responder_if.slave  bus
);
  localparam int             LINE_SIZE = 1 << LINE_ADDR_LEN;
  localparam int             MEM_LINES = 1 << ADDR_LEN;
  localparam logic [7:0]     LAST_CNT  = 8'(LATENCY - 1);

  typedef logic [LINE_SIZE-1:0][31:0] line_t;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic                accept, access;

  logic                op_wr;
  logic [ADDR_LEN-1:0] addr_q;
  line_t               wdata_q;
  line_t               rd_line_q;

  // Lines never written read back their deterministic power-up pattern, so
  // the array itself needs no initialisation and rst never touches it.
  line_t                mem [MEM_LINES];
  logic [MEM_LINES-1:0] written = '0;

  function automatic line_t power_up_line(input logic [ADDR_LEN-1:0] a);
    line_t l;
    for (int w = 0; w < LINE_SIZE; w++) begin
      l[w] = (32'(a) << LINE_ADDR_LEN) + 32'(w);
    end
    return l;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rd_req || bus.wr_req) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + 8'd1;
        if (cnt == LAST_CNT) begin
          access    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.gnt = (state == DONE);

  // Request capture: write wins when both requests are raised together.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.addr;
      op_wr   <= bus.wr_req;
      wdata_q <= bus.wr_line;
    end
  end

  always_ff @(posedge clk) begin
    if (access && op_wr && !rst) begin
      mem[addr_q]     <= wdata_q;
      written[addr_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_line_q <= '0;
    end else if (access && !op_wr) begin
      rd_line_q <= written[addr_q] ? mem[addr_q] : power_up_line(addr_q);
    end
  end

  assign bus.rd_line = rd_line_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: transaction-level memory model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_line_mem_responder;
  localparam int LAL = 3;
  localparam int AL  = 9;
  localparam int LAT = 4;
  localparam int LS  = 1 << LAL;
  localparam int ML  = 1 << AL;

  typedef logic [LS-1:0][31:0] line_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_mem_responder_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL)) bus ();

  line_mem_responder #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int gnt_count = 0;

  // Reference model: memory contents plus the one outstanding transaction,
  // tracked as the number of edges left until it completes.
  line_t        m_mem [ML];
  bit           m_pend = 1'b0;
  bit           m_wr = 1'b0;
  bit           m_gnt = 1'b0;
  int           m_left = 0;
  logic [AL-1:0] m_addr = '0;
  line_t        m_data = '0;
  line_t        m_rd = '0;

  function automatic line_t ramp(input int base);
    line_t l;
    for (int w = 0; w < LS; w++) l[w] = 32'(base + w);
    return l;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0b required=%0b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  // Applies the protocol rules to the inputs sampled at this edge.
  task automatic model_edge();
    if (rst) begin
      m_pend = 1'b0;
      m_gnt  = 1'b0;
      m_rd   = '0;
    end else if (m_gnt) begin
      m_gnt = 1'b0;
    end else if (m_pend) begin
      m_left--;
      if (m_left == 0) begin
        if (m_wr) m_mem[m_addr] = m_data;
        else      m_rd = m_mem[m_addr];
        m_pend = 1'b0;
        m_gnt  = 1'b1;
      end
    end else if (bus.rd_req || bus.wr_req) begin
      m_pend = 1'b1;
      m_left = LAT;
      m_wr   = bus.wr_req;
      m_addr = bus.addr;
      m_data = bus.wr_line;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk_bit("gnt", bus.gnt, m_gnt);
    chk_line("rd_line", bus.rd_line, m_rd);
    if (bus.gnt) gnt_count++;
  endtask

  task automatic set_req(input bit rd, input bit wr, input int a, input line_t d);
    bus.rd_req  = rd;
    bus.wr_req  = wr;
    bus.addr    = AL'(a);
    bus.wr_line = d;
  endtask

  task automatic xfer(input bit rd, input bit wr, input int a, input line_t d,
                      input bit mutate, output int acc, output int gc);
    set_req(rd, wr, a, d);
    acc = cyc + 1;
    gc  = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (mutate && i == 0) begin
        bus.addr    = AL'(7);
        bus.wr_line = ramp('hD000);
      end
      if (bus.gnt) begin
        gc = cyc;
        break;
      end
    end
    checks++;
    if (gc < 0) begin
      errors++;
      $display("FAIL gnt_timeout cycle=%0d actual=none required=gnt within 300 cycles", cyc);
    end
  endtask

  task automatic drop();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    step();
  endtask

  initial begin
    int acc, gc, acc2, gc2, g;
    line_t rl;

    for (int a = 0; a < ML; a++) begin
      for (int w = 0; w < LS; w++) m_mem[a][w] = 32'((a << LAL) + w);
    end
    rst = 1'b1;
    set_req(0, 0, 0, '0);
    step();
    step();
    rst = 1'b0;
    chk_bit("reset_gnt", bus.gnt, 1'b0);
    chk_line("reset_rd_line", bus.rd_line, '0);

    // Plain read of line 5 and its latency
    xfer(1, 0, 5, '0, 0, acc, gc);
    chk_int("rd_latency", gc - acc, LAT);
    chk_line("rd_addr5", bus.rd_line, ramp(40));
    drop();
    chk_bit("gnt_one_cycle", bus.gnt, 1'b0);

    // Write then read back; rd_line must not move on a write
    xfer(0, 1, 5, ramp('hA000), 0, acc, gc);
    chk_line("rd_line_kept_on_write", bus.rd_line, ramp(40));
    drop();
    xfer(1, 0, 5, '0, 0, acc, gc);
    chk_line("raw_addr5", bus.rd_line, ramp('hA000));
    drop();

    // Cache-style write-back then fill, back to back
    g = gnt_count;
    xfer(0, 1, 9, ramp('hB000), 0, acc, gc);
    xfer(1, 0, 3, '0, 0, acc2, gc2);
    chk_int("swap_span", gc2 - acc, 2 * (LAT + 2) - 2);
    chk_line("swap_rd_addr3", bus.rd_line, ramp(24));
    drop();
    chk_int("swap_gnts", gnt_count - g, 2);

    // Address/data changes during BUSY are ignored
    xfer(0, 1, 5, ramp('hC000), 1, acc, gc);
    drop();
    xfer(1, 0, 5, '0, 0, acc, gc);
    chk_line("busy_change_addr5", bus.rd_line, ramp('hC000));
    drop();
    xfer(1, 0, 7, '0, 0, acc, gc);
    chk_line("busy_change_addr7", bus.rd_line, ramp(56));
    drop();

    // Reset two cycles into a write aborts it
    g = gnt_count;
    set_req(0, 1, 2, ramp('hE000));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 0, 0, '0);
    chk_bit("abort_gnt", bus.gnt, 1'b0);
    chk_line("abort_rd_line", bus.rd_line, '0);
    repeat (6) step();
    chk_int("abort_no_gnt", gnt_count - g, 0);
    xfer(1, 0, 2, '0, 0, acc, gc);
    chk_line("abort_rd_addr2", bus.rd_line, ramp(16));
    drop();

    // Simultaneous read and write: write wins, one grant, read not done
    g = gnt_count;
    xfer(1, 1, 1, ramp('hF000), 0, acc, gc);
    drop();
    chk_int("both_gnts", gnt_count - g, 1);
    chk_line("both_no_read", bus.rd_line, ramp(16));
    xfer(1, 0, 1, '0, 0, acc, gc);
    chk_line("both_rd_addr1", bus.rd_line, ramp('hF000));
    drop();

    // Random traffic, including resets and mid-transfer input changes
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      bus.rd_req  = ($urandom_range(0, 2) == 0);
      bus.wr_req  = ($urandom_range(0, 3) == 0);
      bus.addr    = ($urandom_range(0, 3) == 0) ? AL'($urandom) : AL'($urandom_range(0, 15));
      for (int w = 0; w < LS; w++) rl[w] = $urandom;
      bus.wr_line = rl;
      step();
    end
    rst = 1'b0;
    set_req(0, 0, 0, '0);
    repeat (LAT + 3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
